// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register access path.
// Host-visible response status and latency counter sizing.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    OKAY         = 2'b00,
    SLAVE_ERROR  = 2'b10,
    DECODE_ERROR = 2'b11
  } rggen_status;

  localparam int COUNT_WIDTH = 4;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Bit-field access bundle between a register controller
// and the fields of one register.
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);

  logic             write_access;
  logic             read_access;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;

  modport master (
    output write_access,
    output read_access,
    output write_data,
    output write_mask,
    input  read_data
  );

  modport slave (
    input  write_access,
    input  read_access,
    input  write_data,
    input  write_mask,
    output read_data
  );

endinterface

// File: rtl/rggen_access_decoder.sv
// Address hit and permission check for one register.
// OKAY means the request may proceed to a bit-field access.
module rggen_access_decoder
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH  = 8,
  parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
  parameter bit                     READABLE       = 1'b1,
  parameter bit                     WRITABLE       = 1'b1
) (
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     write,
  output rggen_status              status
);

  always_comb begin
    status = OKAY;
    if (address != OFFSET_ADDRESS) begin
      status = DECODE_ERROR;
    end else if (write && !WRITABLE) begin
      status = SLAVE_ERROR;
    end else if (!write && !READABLE) begin
      status = SLAVE_ERROR;
    end
  end

endmodule

// File: rtl/rggen_register_access_ctrl.sv
// Host request to single bit-field access cycle,
// with fixed read latency and a held response.
module rggen_register_access_ctrl
  import rggen_rtl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH  = 8,
  parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
  parameter int                       DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0]    VALID_BITS     = '1,
  parameter bit                       READABLE       = 1'b1,
  parameter bit                       WRITABLE       = 1'b1,
  parameter int                       ACCESS_LATENCY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
  input  logic                      i_req_write,
  input  logic [DATA_WIDTH-1:0]     i_req_data,
  input  logic [DATA_WIDTH/8-1:0]   i_req_strobe,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [1:0]                o_rsp_status,
  output logic [DATA_WIDTH-1:0]     o_rsp_data,
  rggen_bit_field_if.master         bit_field_if
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_INIT =
    (ACCESS_LATENCY == 0) ? '0 :
    COUNT_WIDTH'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESPONSE
  } state_e;

  state_e                  state;
  state_e                  state_next;
  rggen_status             dec_status;
  rggen_status             status_q;
  logic                    accept;
  logic                    capture;
  logic                    write_q;
  logic [COUNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   wmask_q;
  logic [DATA_WIDTH-1:0]   mask_in;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    wr_access;
  logic                    rd_access;

  rggen_access_decoder #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .OFFSET_ADDRESS (OFFSET_ADDRESS),
    .READABLE       (READABLE),
    .WRITABLE       (WRITABLE)
  ) u_decoder (
    .address (i_req_address),
    .write   (i_req_write),
    .status  (dec_status)
  );

  // Unimplemented bits are never write-enabled.
  for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_mask
    assign mask_in[8*i+:8] =
      {8{i_req_strobe[i]}} & VALID_BITS[8*i+:8];
  end

  always_comb begin
    state_next  = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    wr_access   = 1'b0;
    rd_access   = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    unique case (state)
      IDLE: begin
        o_req_ready = !rst;
        accept      = i_req_valid && !rst;
        if (accept) begin
          state_next = (dec_status == OKAY) ?
                       ACCESS : RESPONSE;
        end
      end
      ACCESS: begin
        wr_access = write_q;
        rd_access = !write_q;
        if (ACCESS_LATENCY == 0) begin
          capture    = 1'b1;
          state_next = RESPONSE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (count == '0) begin
          capture    = 1'b1;
          state_next = RESPONSE;
        end
      end
      RESPONSE: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      count      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rsp_data_q <= '0;
      status_q   <= OKAY;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q  <= i_req_write;
        status_q <= dec_status;
        if (dec_status != OKAY) begin
          rsp_data_q <= '0;
        end else if (i_req_write) begin
          wdata_q <= i_req_data;
          wmask_q <= mask_in;
        end
      end
      if (state == ACCESS) begin
        count <= COUNT_INIT;
      end else if (state == WAIT) begin
        count <= count - 1'b1;
      end
      if (capture) begin
        status_q   <= OKAY;
        rsp_data_q <= write_q ? '0 :
          (bit_field_if.read_data & VALID_BITS);
      end
    end
  end

  assign o_rsp_status              = status_q;
  assign o_rsp_data                = rsp_data_q;
  assign bit_field_if.write_access = wr_access;
  assign bit_field_if.read_access  = rd_access;
  assign bit_field_if.write_data   = wdata_q;
  assign bit_field_if.write_mask   = wmask_q;

endmodule

// File: tb/tb_rggen_register_access_ctrl.sv
// Directed bench: three controller instances covering
// normal access, permission errors and read latency.
module tb_rggen_register_access_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  valid;
  logic [2:0]  req_ready;
  logic [7:0]  address;
  logic        write;
  logic [31:0] data;
  logic [3:0]  strobe;
  logic [2:0]  rsp_valid;
  logic        rsp_ready;
  logic [1:0]  st0, st1, st2;
  logic [31:0] rd0, rd1, rd2;
  int          total;
  int          passed;

  rggen_bit_field_if #(.WIDTH(32)) bf0 ();
  rggen_bit_field_if #(.WIDTH(32)) bf1 ();
  rggen_bit_field_if #(.WIDTH(32)) bf2 ();

  rggen_register_access_ctrl #(
    .OFFSET_ADDRESS (8'h10),
    .VALID_BITS     (32'h00FF_FFFF),
    .ACCESS_LATENCY (0)
  ) dut0 (
    .clk (clk), .rst (rst),
    .i_req_valid (valid[0]), .o_req_ready (req_ready[0]),
    .i_req_address (address), .i_req_write (write),
    .i_req_data (data), .i_req_strobe (strobe),
    .o_rsp_valid (rsp_valid[0]), .i_rsp_ready (rsp_ready),
    .o_rsp_status (st0), .o_rsp_data (rd0),
    .bit_field_if (bf0)
  );

  rggen_register_access_ctrl #(
    .OFFSET_ADDRESS (8'h10),
    .WRITABLE       (1'b0),
    .ACCESS_LATENCY (3)
  ) dut1 (
    .clk (clk), .rst (rst),
    .i_req_valid (valid[1]), .o_req_ready (req_ready[1]),
    .i_req_address (address), .i_req_write (write),
    .i_req_data (data), .i_req_strobe (strobe),
    .o_rsp_valid (rsp_valid[1]), .i_rsp_ready (rsp_ready),
    .o_rsp_status (st1), .o_rsp_data (rd1),
    .bit_field_if (bf1)
  );

  rggen_register_access_ctrl #(
    .OFFSET_ADDRESS (8'h10),
    .READABLE       (1'b0),
    .ACCESS_LATENCY (0)
  ) dut2 (
    .clk (clk), .rst (rst),
    .i_req_valid (valid[2]), .o_req_ready (req_ready[2]),
    .i_req_address (address), .i_req_write (write),
    .i_req_data (data), .i_req_strobe (strobe),
    .o_rsp_valid (rsp_valid[2]), .i_rsp_ready (rsp_ready),
    .o_rsp_status (st2), .o_rsp_data (rd2),
    .bit_field_if (bf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request cycle; returns at the negedge of
  // the cycle following acceptance.
  task automatic request(input int sel, input logic [7:0] a,
                         input logic w, input logic [31:0] d,
                         input logic [3:0] s);
    @(negedge clk);
    address = a;
    write = w;
    data = d;
    strobe = s;
    valid[sel] = 1'b1;
    @(negedge clk);
    valid = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 3'b000)
      $display("FAIL reset_ready_in_rst: got %b want 000", req_ready);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 3'b111 || rsp_valid !== 3'b000)
      $display("FAIL reset_handshake: ready %b valid %b want 111 000",
               req_ready, rsp_valid);
    else passed++;
    total++;
    if (st0 !== 2'b00 || rd0 !== 32'h0)
      $display("FAIL reset_rsp: status %b data %h want 00 0", st0, rd0);
    else passed++;
    total++;
    if ({bf0.write_access, bf0.read_access} !== 2'b00 ||
        bf0.write_data !== 32'h0 || bf0.write_mask !== 32'h0)
      $display("FAIL reset_bf: wa %b ra %b wd %h wm %h want 0",
               bf0.write_access, bf0.read_access,
               bf0.write_data, bf0.write_mask);
    else passed++;
  endtask

  task automatic test_write();
    @(negedge clk);
    total++;
    if (req_ready[0] !== 1'b1)
      $display("FAIL write_ready: got %b want 1", req_ready[0]);
    else passed++;
    request(0, 8'h10, 1'b1, 32'hA5A5_5A5A, 4'b0011);
    total++;
    if (bf0.write_access !== 1'b1 || bf0.read_access !== 1'b0)
      $display("FAIL write_strobe: wa %b ra %b want 1 0",
               bf0.write_access, bf0.read_access);
    else passed++;
    total++;
    if (bf0.write_mask !== 32'h0000_FFFF)
      $display("FAIL write_mask: got %h want 0000ffff", bf0.write_mask);
    else passed++;
    total++;
    if (bf0.write_data !== 32'hA5A5_5A5A)
      $display("FAIL write_data: got %h want a5a55a5a", bf0.write_data);
    else passed++;
    total++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0)
      $display("FAIL write_busy: valid %b ready %b want 0 0",
               rsp_valid[0], req_ready[0]);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b1 || st0 !== 2'b00 || rd0 !== 32'h0)
      $display("FAIL write_rsp: valid %b status %b data %h want 1 00 0",
               rsp_valid[0], st0, rd0);
    else passed++;
    total++;
    if (bf0.write_access !== 1'b0 || bf0.write_mask !== 32'h0000_FFFF)
      $display("FAIL write_hold: wa %b wm %h want 0 0000ffff",
               bf0.write_access, bf0.write_mask);
    else passed++;
    handshake();
    total++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
      $display("FAIL write_done: valid %b ready %b want 0 1",
               rsp_valid[0], req_ready[0]);
    else passed++;
  endtask

  task automatic test_read();
    bf0.read_data = 32'h1234_5678;
    request(0, 8'h10, 1'b0, 32'hFFFF_FFFF, 4'b1111);
    total++;
    if (bf0.read_access !== 1'b1 || bf0.write_access !== 1'b0)
      $display("FAIL read_strobe: ra %b wa %b want 1 0",
               bf0.read_access, bf0.write_access);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b1 || st0 !== 2'b00 || rd0 !== 32'h0034_5678)
      $display("FAIL read_rsp: valid %b status %b data %h want 1 00 00345678",
               rsp_valid[0], st0, rd0);
    else passed++;
    handshake();
  endtask

  task automatic test_decode_error();
    request(0, 8'h14, 1'b1, 32'hFFFF_FFFF, 4'b1111);
    total++;
    if (rsp_valid[0] !== 1'b1 || st0 !== 2'b11 || rd0 !== 32'h0)
      $display("FAIL decode_rsp: valid %b status %b data %h want 1 11 0",
               rsp_valid[0], st0, rd0);
    else passed++;
    total++;
    if ({bf0.write_access, bf0.read_access} !== 2'b00 ||
        bf0.write_data !== 32'hA5A5_5A5A)
      $display("FAIL decode_bf: strobes %b wd %h want 00 a5a55a5a",
               {bf0.write_access, bf0.read_access}, bf0.write_data);
    else passed++;
    handshake();
    request(0, 8'h14, 1'b0, 32'h0, 4'b0000);
    total++;
    if (st0 !== 2'b11 || bf0.read_access !== 1'b0)
      $display("FAIL decode_read: status %b ra %b want 11 0",
               st0, bf0.read_access);
    else passed++;
    handshake();
  endtask

  task automatic test_zero_strobe();
    request(0, 8'h10, 1'b1, 32'h5555_AAAA, 4'b0000);
    total++;
    if (bf0.write_access !== 1'b1 || bf0.write_mask !== 32'h0)
      $display("FAIL zero_strobe: wa %b wm %h want 1 0",
               bf0.write_access, bf0.write_mask);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b1 || st0 !== 2'b00)
      $display("FAIL zero_strobe_rsp: valid %b status %b want 1 00",
               rsp_valid[0], st0);
    else passed++;
    handshake();
  endtask

  task automatic test_slave_error();
    request(1, 8'h10, 1'b1, 32'hFFFF_FFFF, 4'b1111);
    total++;
    if (rsp_valid[1] !== 1'b1 || st1 !== 2'b10 || rd1 !== 32'h0)
      $display("FAIL wr_protect: valid %b status %b data %h want 1 10 0",
               rsp_valid[1], st1, rd1);
    else passed++;
    total++;
    if (bf1.write_access !== 1'b0 || bf1.write_mask !== 32'h0)
      $display("FAIL wr_protect_bf: wa %b wm %h want 0 0",
               bf1.write_access, bf1.write_mask);
    else passed++;
    handshake();
    bf2.read_data = 32'hFFFF_FFFF;
    request(2, 8'h10, 1'b0, 32'h0, 4'b0000);
    total++;
    if (rsp_valid[2] !== 1'b1 || st2 !== 2'b10 || rd2 !== 32'h0)
      $display("FAIL rd_protect: valid %b status %b data %h want 1 10 0",
               rsp_valid[2], st2, rd2);
    else passed++;
    total++;
    if (bf2.read_access !== 1'b0)
      $display("FAIL rd_protect_bf: ra %b want 0", bf2.read_access);
    else passed++;
    handshake();
    request(2, 8'h10, 1'b1, 32'h0000_00C3, 4'b0001);
    total++;
    if (bf2.write_access !== 1'b1 || bf2.write_mask !== 32'h0000_00FF)
      $display("FAIL rd_protect_wr: wa %b wm %h want 1 000000ff",
               bf2.write_access, bf2.write_mask);
    else passed++;
    @(negedge clk);
    handshake();
  endtask

  task automatic test_latency();
    bf1.read_data = 32'hDEAD_0001;
    request(1, 8'h10, 1'b0, 32'h0, 4'b0000);
    total++;
    if (bf1.read_access !== 1'b1)
      $display("FAIL lat_strobe: ra %b want 1", bf1.read_access);
    else passed++;
    bf1.read_data = 32'hDEAD_0002;
    @(negedge clk);
    bf1.read_data = 32'hDEAD_0003;
    @(negedge clk);
    total++;
    if (rsp_valid[1] !== 1'b0 || bf1.read_access !== 1'b0)
      $display("FAIL lat_wait: valid %b ra %b want 0 0",
               rsp_valid[1], bf1.read_access);
    else passed++;
    bf1.read_data = 32'hCAFE_F00D;
    @(negedge clk);
    total++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0)
      $display("FAIL lat_wait_end: valid %b ready %b want 0 0",
               rsp_valid[1], req_ready[1]);
    else passed++;
    @(negedge clk);
    bf1.read_data = 32'h1111_1111;
    total++;
    if (rsp_valid[1] !== 1'b1 || st1 !== 2'b00 || rd1 !== 32'hCAFE_F00D)
      $display("FAIL lat_rsp: valid %b status %b data %h want 1 00 cafef00d",
               rsp_valid[1], st1, rd1);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid[1] !== 1'b1 || rd1 !== 32'hCAFE_F00D ||
          st1 !== 2'b00 || req_ready[1] !== 1'b0)
        $display("FAIL lat_hold%0d: valid %b data %h status %b ready %b want 1 cafef00d 00 0",
                 i, rsp_valid[1], rd1, st1, req_ready[1]);
      else passed++;
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    bf1.read_data = 32'h7777_7777;
    request(1, 8'h10, 1'b0, 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 3'b000 || req_ready !== 3'b000 ||
        bf1.read_access !== 1'b0)
      $display("FAIL rst_mid_ctrl: valid %b ready %b ra %b want 000 000 0",
               rsp_valid, req_ready, bf1.read_access);
    else passed++;
    total++;
    if (rd1 !== 32'h0 || st1 !== 2'b00 || bf0.write_data !== 32'h0)
      $display("FAIL rst_mid_data: data %h status %b wd %h want 0 00 0",
               rd1, st1, bf0.write_data);
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid[1] !== 1'b0 || bf1.read_access !== 1'b0)
        $display("FAIL rst_mid_quiet%0d: valid %b ra %b want 0 0",
                 i, rsp_valid[1], bf1.read_access);
      else passed++;
    end
    bf1.read_data = 32'h0BAD_BEEF;
    request(1, 8'h10, 1'b0, 32'h0, 4'b0000);
    repeat (4) @(negedge clk);
    total++;
    if (rsp_valid[1] !== 1'b1 || rd1 !== 32'h0BAD_BEEF || st1 !== 2'b00)
      $display("FAIL rst_mid_next: valid %b data %h status %b want 1 0badbeef 00",
               rsp_valid[1], rd1, st1);
    else passed++;
    handshake();
  endtask

  task automatic test_back_to_back();
    request(0, 8'h10, 1'b1, 32'h1111_2222, 4'b1111);
    @(negedge clk);
    data = 32'h3333_4444;
    strobe = 4'b1100;
    write = 1'b1;
    valid[0] = 1'b1;
    handshake();
    total++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 ||
        bf0.write_access !== 1'b0)
      $display("FAIL b2b_gap: valid %b ready %b wa %b want 0 1 0",
               rsp_valid[0], req_ready[0], bf0.write_access);
    else passed++;
    @(negedge clk);
    valid = '0;
    total++;
    if (bf0.write_access !== 1'b1 || bf0.write_data !== 32'h3333_4444 ||
        bf0.write_mask !== 32'h00FF_0000)
      $display("FAIL b2b_second: wa %b wd %h wm %h want 1 33334444 00ff0000",
               bf0.write_access, bf0.write_data, bf0.write_mask);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b1 || st0 !== 2'b00)
      $display("FAIL b2b_rsp: valid %b status %b want 1 00",
               rsp_valid[0], st0);
    else passed++;
    handshake();
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    valid = '0;
    address = '0;
    write = 1'b0;
    data = '0;
    strobe = '0;
    rsp_ready = 1'b0;
    bf0.read_data = '0;
    bf1.read_data = '0;
    bf2.read_data = '0;
    test_reset();
    test_write();
    test_read();
    test_decode_error();
    test_zero_strobe();
    test_slave_error();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
